ucode_sequencer: RTL and testbench

Parametrised microcode sequencer for the 6502 core: generates the per-instruction step count, picks the effective opcode at each instruction boundary, and registers the control word from the external PLA onto the datapath strobes. It adds the following to the fixed 3-bit microclock/control-register stage:
- configurable control and step widths
- an end-of-instruction handshake with the PLA
- RDY stalling
- NMI/IRQ/RESET sequence injection
- step-overflow detection

It sits between the instruction register and the datapath, with the PLA as a combinational lookup alongside it.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/irq_arbiter.sv | 88 ++++++++
 rtl/ucode_sequencer.sv | 127 ++++++++++++
 tb/tb_ucode_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the 6502 core. Holds the interrupt
//                vector selectors, the opcode used for injected BRK-style
//                sequences, and the bit layout of the PLA control word.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Microcode geometry
  localparam int CTRL_W = 27;   // datapath control word width
  localparam int STEP_W = 3;    // microstep counter width

  // Opcode injected for RESET / NMI / IRQ sequences
  localparam logic [7:0] BRK_OP = 8'h00;

  // Vector selectors presented to the address generator
  localparam logic [1:0] VEC_RESET = 2'd0;
  localparam logic [1:0] VEC_NMI   = 2'd1;
  localparam logic [1:0] VEC_IRQ   = 2'd2;

  // Control-word bit indices; must match the column order of the PLA
  localparam int CB_PC_INC  = 0;   // increment program counter
  localparam int CB_PC_LOAD = 1;   // load PC from address bus latch
  localparam int CB_AB_PC   = 2;   // address bus sourced from PC
  localparam int CB_AB_ADL  = 3;   // address bus sourced from ADL/ADH
  localparam int CB_IR_LOAD = 4;   // latch instruction register
  localparam int CB_A_LOAD  = 5;   // accumulator write enable
  localparam int CB_X_LOAD  = 6;   // X index write enable
  localparam int CB_Y_LOAD  = 7;   // Y index write enable
  localparam int CB_S_LOAD  = 8;   // stack pointer write enable
  localparam int CB_P_LOAD  = 9;   // status register write enable
  localparam int CB_ALU_OP  = 10;  // first of four ALU operation bits
  localparam int CB_DB_SEL  = 14;  // first of four data-bus source bits
  localparam int CB_SB_SEL  = 18;  // first of four special-bus source bits
  localparam int CB_ADL_SEL = 22;  // first of two ADL source bits
  localparam int CB_ADH_SEL = 24;  // first of two ADH source bits
  localparam int RW_BIT     = 26;  // 1 = write cycle

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : irq_arbiter
//  Description : Chooses the opcode and vector for the next instruction at an
//                instruction boundary. Holds the NMI edge detector, the NMI
//                pending flag and the reset-sequence flag.
//  Ports       : clk, rst_n         - falling-edge clock, async active-low reset
//                nmi, irq, irq_mask - interrupt request lines and P.I flag
//                insn               - opcode from the instruction register
//                boundary           - this negedge ends the current instruction
//                sel_op, sel_vec    - selected opcode / vector
//                rst_seq            - the reset sequence is still running
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
  parameter logic [7:0] BRK_OP = cpu_pkg::BRK_OP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       nmi,
  input  logic       irq,
  input  logic       irq_mask,
  input  logic [7:0] insn,
  input  logic       boundary,
  output logic [7:0] sel_op,
  output logic [1:0] sel_vec,
  output logic       rst_seq
);

  import cpu_pkg::*;

  logic r_nmi_q;
  logic r_nmi_pend;
  logic r_rst_pend;

  logic w_nmi_edge;
  logic w_nmi_req;
  logic w_take_nmi;

  // An edge seen on this very negedge may be injected immediately if the
  // negedge is also a boundary, so the request merges flag and edge.
  assign w_nmi_edge = nmi & ~r_nmi_q;
  assign w_nmi_req  = r_nmi_pend | w_nmi_edge;

  // Reset applies the reset entry of the priority list directly: the
  // sequencer comes out of reset already holding BRK_OP with the RESET
  // vector. The pending flag therefore stays up for the duration of that
  // sequence (it gates the forced-read window) and is retired at its
  // boundary, where selection falls through to the remaining entries.
  always_comb begin
    sel_op     = insn;
    sel_vec    = VEC_IRQ;
    w_take_nmi = 1'b0;
    if (w_nmi_req) begin
      sel_op     = BRK_OP;
      sel_vec    = VEC_NMI;
      w_take_nmi = 1'b1;
    end else if (irq && !irq_mask) begin
      sel_op  = BRK_OP;
      sel_vec = VEC_IRQ;
    end
  end

  assign rst_seq = r_rst_pend;

  // Edge detection runs on every negedge, stalled or not.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nmi_q    <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_rst_pend <= 1'b1;
    end else begin
      r_nmi_q <= nmi;
      if (boundary && w_take_nmi) begin
        // Serving an already pending NMI while a fresh edge arrives keeps the
        // flag set; serving a same-cycle edge leaves nothing behind.
        r_nmi_pend <= r_nmi_pend & w_nmi_edge;
      end else begin
        r_nmi_pend <= w_nmi_req;
      end
      if (boundary) begin
        r_rst_pend <= 1'b0;
      end
    end
  end

endmodule : irq_arbiter
`default_nettype wire

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ucode_sequencer
//  Description : Microcode sequencer for the 6502 core. Counts microsteps,
//                picks the effective opcode at each instruction boundary and
//                registers the PLA control word onto the datapath strobes.
//                All state changes on the falling clock edge.
//  Ports       : clk, rst_n         - clock (negedge active), async reset
//                insn               - opcode from instruction-register bus
//                rdy                - 0 requests a stall on read cycles
//                nmi, irq, irq_mask - interrupt inputs
//                pla_ctrl, pla_last - PLA lookup for (op_eff, step)
//                op_eff, step       - PLA address
//                ctrl               - registered control word
//                vec_sel            - vector of the injected sequence
//                sync               - opcode-fetch cycle (step == 0)
//                step_err           - sticky step-overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module ucode_sequencer #(
  parameter int         CTRL_W = cpu_pkg::CTRL_W,
  parameter int         STEP_W = cpu_pkg::STEP_W,
  parameter int         RW_BIT = cpu_pkg::RW_BIT,
  parameter logic [7:0] BRK_OP = cpu_pkg::BRK_OP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        insn,
  input  logic              rdy,
  input  logic              nmi,
  input  logic              irq,
  input  logic              irq_mask,
  input  logic [CTRL_W-1:0] pla_ctrl,
  input  logic              pla_last,
  output logic [7:0]        op_eff,
  output logic [STEP_W-1:0] step,
  output logic [CTRL_W-1:0] ctrl,
  output logic [1:0]        vec_sel,
  output logic              sync,
  output logic              step_err
);

  import cpu_pkg::*;

  localparam logic [STEP_W-1:0] c_step_one = STEP_W'(1);
  localparam logic [STEP_W-1:0] c_step_max = {STEP_W{1'b1}};

  logic [STEP_W-1:0] r_step;
  logic [CTRL_W-1:0] r_ctrl;
  logic [7:0]        r_op_eff;
  logic [1:0]        r_vec_sel;
  logic              r_step_err;

  logic              w_advance;
  logic              w_step_max;
  logic              w_overflow;
  logic              w_boundary;
  logic              w_rst_seq;
  logic [7:0]        w_sel_op;
  logic [1:0]        w_sel_vec;
  logic [CTRL_W-1:0] w_ctrl_next;

  // The registered control word describes the cycle now on the bus, so its
  // rw bit decides whether rdy may stall it: writes always complete.
  assign w_advance  = rdy | r_ctrl[RW_BIT];
  assign w_step_max = (r_step == c_step_max);

  // Running off the end of the counter is treated as an implicit final step
  // so the machine always recovers to a fresh opcode.
  assign w_overflow = w_advance & w_step_max & ~pla_last;
  assign w_boundary = w_advance & (pla_last | w_step_max);

  // Reset sequence is read-only regardless of what the PLA says, so a
  // half-initialised stack pointer can never be written through.
  always_comb begin
    w_ctrl_next = pla_ctrl;
    if (w_rst_seq) begin
      w_ctrl_next[RW_BIT] = 1'b0;
    end
  end

  irq_arbiter #(
    .BRK_OP (BRK_OP)
  ) u_irq_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .nmi      (nmi),
    .irq      (irq),
    .irq_mask (irq_mask),
    .insn     (insn),
    .boundary (w_boundary),
    .sel_op   (w_sel_op),
    .sel_vec  (w_sel_vec),
    .rst_seq  (w_rst_seq)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step     <= '0;
      r_ctrl     <= '0;
      r_op_eff   <= BRK_OP;
      r_vec_sel  <= VEC_RESET;
      r_step_err <= 1'b0;
    end else if (w_advance) begin
      r_ctrl <= w_ctrl_next;
      if (w_boundary) begin
        r_step    <= '0;
        r_op_eff  <= w_sel_op;
        r_vec_sel <= w_sel_vec;
      end else begin
        r_step <= r_step + c_step_one;
      end
      if (w_overflow) begin
        r_step_err <= 1'b1;
      end
    end
  end

  assign op_eff   = r_op_eff;
  assign step     = r_step;
  assign ctrl     = r_ctrl;
  assign vec_sel  = r_vec_sel;
  assign sync     = (r_step == '0);
  assign step_err = r_step_err;

endmodule : ucode_sequencer
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ucode_sequencer
//  Description : Self-checking bench for ucode_sequencer. A stub PLA feeds the
//                DUT; an independent instruction-level model predicts every
//                output each cycle, and a few literal expectations pin the
//                model on the reset, overflow and reset-mid-op scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

  localparam int CW = 27;
  localparam int RW = 26;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    insn = 8'hA9;
  logic          rdy = 1'b1;
  logic          nmi = 1'b0;
  logic          irq = 1'b0;
  logic          irq_mask = 1'b1;
  logic [CW-1:0] pla_ctrl;
  logic          pla_last;
  logic [7:0]    op_eff;
  logic [2:0]    step;
  logic [CW-1:0] ctrl;
  logic [1:0]    vec_sel;
  logic          sync;
  logic          step_err;

  // Stub PLA configuration
  int            pm = 1;         // 0 = per-opcode table, 1 = fixed, 2 = never last
  int            rm = 1;         // 0 = hashed rw, 1 = always write, 2 = always read
  logic [2:0]    fix_last = 3'd6;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] stub_ctrl(input logic [7:0] op, input logic [2:0] st,
                                              input int rmode);
    logic [31:0]   h;
    logic [CW-1:0] w;
    h = ({24'd0, op} * 32'h9E3779B1) ^ (({29'd0, st} + 32'd1) * 32'h85EBCA6B);
    w = h[CW-1:0];
    if (rmode == 1) w[RW] = 1'b1;
    else if (rmode == 2) w[RW] = 1'b0;
    return w;
  endfunction

  function automatic logic stub_last(input logic [7:0] op, input logic [2:0] st,
                                     input int pmode, input logic [2:0] fl);
    if (pmode == 0) return st == (op[2:0] ^ op[7:5]);
    if (pmode == 1) return st == fl;
    return 1'b0;
  endfunction

  assign pla_ctrl = stub_ctrl(op_eff, step, rm);
  assign pla_last = stub_last(op_eff, step, pm, fix_last);

  ucode_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .insn     (insn),
    .rdy      (rdy),
    .nmi      (nmi),
    .irq      (irq),
    .irq_mask (irq_mask),
    .pla_ctrl (pla_ctrl),
    .pla_last (pla_last),
    .op_eff   (op_eff),
    .step     (step),
    .ctrl     (ctrl),
    .vec_sel  (vec_sel),
    .sync     (sync),
    .step_err (step_err)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]    step;
    logic [7:0]    op;
    logic [1:0]    vec;
    logic [CW-1:0] ctrl;
    logic          err;
    logic          rst_seq;
    logic          nmi_pend;
    logic          nmi_prev;
  } mst_t;

  mst_t m;

  function automatic mst_t model_reset();
    mst_t r;
    r = '0;
    r.rst_seq = 1'b1;   // instruction after reset is the BRK/RESET sequence
    return r;
  endfunction

  function automatic mst_t model_next(input mst_t s, input logic i_rdy, input logic i_nmi,
                                      input logic i_irq, input logic i_mask, input logic [7:0] i_insn,
                                      input int pmode, input int rmode, input logic [2:0] fl);
    mst_t          n;
    int            reqs;
    logic [CW-1:0] w;
    logic          last;
    n = s;
    // Outstanding NMI requests: a new edge adds one, a service removes one,
    // and the flag means "at least one left".
    reqs = (s.nmi_pend ? 1 : 0) + ((i_nmi && !s.nmi_prev) ? 1 : 0);
    n.nmi_prev = i_nmi;
    if (i_rdy || s.ctrl[RW]) begin
      w    = stub_ctrl(s.op, s.step, rmode);
      last = stub_last(s.op, s.step, pmode, fl);
      if (s.rst_seq) w[RW] = 1'b0;
      n.ctrl = w;
      if (last || s.step == 3'd7) begin
        if (!last) n.err = 1'b1;
        n.step    = 3'd0;
        n.rst_seq = 1'b0;
        if (reqs > 0) begin
          n.op = 8'h00; n.vec = 2'd1; reqs = reqs - 1;
        end else if (i_irq && !i_mask) begin
          n.op = 8'h00; n.vec = 2'd2;
        end else begin
          n.op = i_insn; n.vec = 2'd2;
        end
      end else begin
        n.step = s.step + 3'd1;
      end
    end
    n.nmi_pend = (reqs > 0);
    return n;
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= model_next(m, rdy, nmi, irq, irq_mask, insn, pm, rm, fix_last);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every posedge, half a cycle away from the active edge
  always @(posedge clk) begin
    if (chk_en) begin
      cmp("step",     {29'd0, step},     {29'd0, m.step});
      cmp("op_eff",   {24'd0, op_eff},   {24'd0, m.op});
      cmp("vec_sel",  {30'd0, vec_sel},  {30'd0, m.vec});
      cmp("ctrl",     {5'd0, ctrl},      {5'd0, m.ctrl});
      cmp("sync",     {31'd0, sync},     {31'd0, (m.step == 3'd0)});
      cmp("step_err", {31'd0, step_err}, {31'd0, m.err});
    end
  end

  initial begin
    bit found;

    // Reset state
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #2;
    cmp("rst_step",  {29'd0, step}, 32'd0);
    cmp("rst_op",    {24'd0, op_eff}, 32'h00);
    cmp("rst_vec",   {30'd0, vec_sel}, 32'd0);
    cmp("rst_ctrl",  {5'd0, ctrl}, 32'd0);
    cmp("rst_sync",  {31'd0, sync}, 32'd1);
    cmp("rst_err",   {31'd0, step_err}, 32'd0);

    // Reset release: 7-step reset sequence, all reads even though PLA says write
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #2;
      cmp("rseq_rw", {31'd0, ctrl[RW]}, 32'd0);
      if (i < 7) begin
        cmp("rseq_op",  {24'd0, op_eff}, 32'h00);
        cmp("rseq_vec", {30'd0, vec_sel}, 32'd0);
      end else begin
        cmp("rseq_next_op",  {24'd0, op_eff}, 32'hA9);
        cmp("rseq_next_vec", {30'd0, vec_sel}, 32'd2);
      end
    end

    // Two-step instructions
    fix_last = 3'd1; insn = 8'hEA; rm = 0;
    repeat (12) @(posedge clk);

    // NMI pulse + IRQ level mid-instruction, then masked IRQ
    fix_last = 3'd3; irq_mask = 1'b0; irq = 1'b1;
    @(posedge clk); nmi = 1'b1;
    @(posedge clk); nmi = 1'b0;
    repeat (10) @(posedge clk);
    irq_mask = 1'b1;
    repeat (8) @(posedge clk);
    irq = 1'b0;

    // RDY stall on reads, then rdy low on writes
    rm = 2;
    repeat (2) @(posedge clk);
    rdy = 1'b0; repeat (3) @(posedge clk); rdy = 1'b1;
    repeat (4) @(posedge clk);
    rm = 1;
    @(posedge clk);
    rdy = 1'b0; repeat (3) @(posedge clk); rdy = 1'b1;
    repeat (4) @(posedge clk);

    // Randomised traffic
    pm = 0; rm = 0;
    repeat (3000) begin
      @(posedge clk);
      rdy  = ($urandom_range(0, 3) != 0);
      nmi  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)  irq = ~irq;
      if ($urandom_range(0, 15) == 0) irq_mask = ~irq_mask;
      insn = 8'($urandom);
    end

    // Overflow: PLA never signals the last step
    @(posedge clk);
    pm = 2; rm = 0; rdy = 1'b1; nmi = 1'b0; irq = 1'b0; insn = 8'h5A;
    repeat (20) @(posedge clk);
    #2;
    cmp("ovf_err", {31'd0, step_err}, 32'd1);
    cmp("ovf_op",  {24'd0, op_eff}, 32'h5A);
    repeat (9) @(posedge clk);
    #2 cmp("ovf_err_sticky", {31'd0, step_err}, 32'd1);

    // Reset pulled at step 4
    pm = 1; fix_last = 3'd6; rm = 1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      if (m.step == 3'd4) found = 1'b1;
    end
    cmp("wait_step4_timeout", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    cmp("mid_rst_step", {29'd0, step}, 32'd0);
    cmp("mid_rst_ctrl", {5'd0, ctrl}, 32'd0);
    cmp("mid_rst_err",  {31'd0, step_err}, 32'd0);
    cmp("mid_rst_op",   {24'd0, op_eff}, 32'h00);
    @(posedge clk); #2 rst_n = 1'b1;
    insn = 8'hA9;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #2;
      cmp("rseq2_rw", {31'd0, ctrl[RW]}, 32'd0);
    end
    cmp("rseq2_op", {24'd0, op_eff}, 32'hA9);
    repeat (4) @(posedge clk);

    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ucode_sequencer
`default_nettype wire
